egress_class_arbiter: RTL and testbench

EGRESS_CLASS_ARBITER -- requirements
Module: egress_class_arbiter

---
 rtl/egress_class_arbiter_pkg.sv | 18 +
 rtl/egress_class_arbiter_arb_credit_fsm.sv | 82 ++++++++
 rtl/egress_class_arbiter.sv | 102 ++++++++++
 tb/tb_egress_class_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_class_arbiter_pkg.sv
// Shared state encoding, widths and helpers for the egress class arbiter.
// Optional grant counters are enabled with ARB_GRANT_CNT_EN.
package egress_class_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_t;

  localparam int CREDIT_W = 4;
  localparam int GCNT_W   = 16;

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/egress_class_arbiter_arb_credit_fsm.sv
// Weighted two-class service FSM: picks a class, spends its credit one pop at a time,
// and hands over to the other class when credit runs out or its FIFO drains.
module arb_credit_fsm
  import egress_class_arbiter_pkg::*;
#(
  parameter int WEIGHT0 = 1,
  parameter int WEIGHT1 = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_eligible,
  input  logic i_fifo0_empty,
  input  logic i_fifo1_empty,
  output logic o_read0,
  output logic o_read1
);

  localparam logic [CREDIT_W-1:0] W0  = CREDIT_W'(WEIGHT0);
  localparam logic [CREDIT_W-1:0] W1  = CREDIT_W'(WEIGHT1);
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);

  arb_state_t            r_state;
  logic [CREDIT_W-1:0]   r_credit;

  // Pop strobes follow the live empty/pause flags so a pop never lands on an empty FIFO.
  assign o_read0 = i_eligible && (r_state == SERVE0) && !i_fifo0_empty;
  assign o_read1 = i_eligible && (r_state == SERVE1) && !i_fifo1_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_credit <= '0;
    end else if (i_eligible) begin
      case (r_state)
        IDLE: begin
          if (!i_fifo1_empty) begin
            r_state  <= SERVE1;
            r_credit <= W1;
          end else if (!i_fifo0_empty) begin
            r_state  <= SERVE0;
            r_credit <= W0;
          end
        end
        SERVE0: begin
          if (i_fifo0_empty || r_credit <= ONE) begin
            if (!i_fifo1_empty) begin
              r_state  <= SERVE1;
              r_credit <= W1;
            end else if (!i_fifo0_empty) begin
              r_credit <= W0;
            end else begin
              r_state  <= IDLE;
              r_credit <= '0;
            end
          end else begin
            r_credit <= r_credit - 1'b1;
          end
        end
        SERVE1: begin
          if (i_fifo1_empty || r_credit <= ONE) begin
            if (!i_fifo0_empty) begin
              r_state  <= SERVE0;
              r_credit <= W0;
            end else if (!i_fifo1_empty) begin
              r_credit <= W1;
            end else begin
              r_state  <= IDLE;
              r_credit <= '0;
            end
          end else begin
            r_credit <= r_credit - 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/egress_class_arbiter.sv
// Two-class egress merger: credit FSM issues pops, a 2-stage pipeline returns the words.
// Define ARB_GRANT_CNT_EN to add saturating per-class grant counters.
module egress_class_arbiter
  import egress_class_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 1,
  parameter int WEIGHT1   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo0_empty,
  input  logic                 fifo1_empty,
  input  logic                 fifo0_error,
  input  logic                 fifo1_error,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  input  logic                 pause_in,
  output logic                 read0,
  output logic                 read1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 arb_error
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [GCNT_W-1:0]    grant_cnt0,
  output logic [GCNT_W-1:0]    grant_cnt1
`endif
);

  logic                 w_eligible;
  logic                 w_read0;
  logic                 w_read1;
  logic                 r_arb_error;
  logic                 r_vld1;
  logic                 r_sel1;
  logic                 r_valid_out;
  logic [DATA_SIZE-1:0] r_data_out;

  // No pops while held in reset, paused, or after a FIFO fault.
  assign w_eligible = reset && !pause_in && !r_arb_error;

  arb_credit_fsm #(
    .WEIGHT0(WEIGHT0),
    .WEIGHT1(WEIGHT1)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_eligible   (w_eligible),
    .i_fifo0_empty(fifo0_empty),
    .i_fifo1_empty(fifo1_empty),
    .o_read0      (w_read0),
    .o_read1      (w_read1)
  );

  // Stage 1 remembers which FIFO was popped; FIFO data arrives one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_arb_error <= 1'b0;
      r_vld1      <= 1'b0;
      r_sel1      <= 1'b0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (fifo0_error || fifo1_error) begin
        r_arb_error <= 1'b1;
      end
      r_vld1      <= w_read0 || w_read1;
      r_sel1      <= w_read1;
      r_valid_out <= r_vld1;
      if (r_vld1) begin
        r_data_out <= r_sel1 ? in1 : in0;
      end
    end
  end

  assign read0     = w_read0;
  assign read1     = w_read1;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign arb_error = r_arb_error;

`ifdef ARB_GRANT_CNT_EN
  logic [1:0] w_read_vec;
  assign w_read_vec = {w_read1, w_read0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_gcnt
    logic [GCNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_read_vec[gi]) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  assign grant_cnt0 = g_gcnt[0].r_cnt;
  assign grant_cnt1 = g_gcnt[1].r_cnt;
`endif

endmodule

// File: tb/tb_egress_class_arbiter.sv
// Directed bench for egress_class_arbiter with queue-backed FIFO models.
// Build with ARB_GRANT_CNT_EN defined to also exercise the grant counters.
module tb_egress_class_arbiter;

  localparam int DW = 10;

  logic          clk;
  logic          reset;
  logic          fifo0_empty;
  logic          fifo1_empty;
  logic          fifo0_error;
  logic          fifo1_error;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic          pause_in;
  logic          read0;
  logic          read1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          arb_error;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0]   grant_cnt0;
  logic [15:0]   grant_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          last_r0;
  logic          last_r1;
  logic [DW-1:0] exp_data;

  // Schedules: '-' no pop, '0'/'1' pop of that class, 'p' paused cycle with no pop.
  string         sched_tbl [4] = '{"-1110111011-000000--", "-000--", "-1-0--", "-11pppp101-000--"};
  int            n0_tbl [4]    = '{8, 3, 1, 4};
  int            n1_tbl [4]    = '{8, 0, 1, 4};
  logic [DW-1:0] b0_tbl [4]    = '{10'h010, 10'h005, 10'h030, 10'h020};
  logic [DW-1:0] b1_tbl [4]    = '{10'h210, 10'h200, 10'h230, 10'h220};

  egress_class_arbiter #(
    .DATA_SIZE(DW),
    .WEIGHT0  (1),
    .WEIGHT1  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo0_empty(fifo0_empty),
    .fifo1_empty(fifo1_empty),
    .fifo0_error(fifo0_error),
    .fifo1_error(fifo1_error),
    .in0        (in0),
    .in1        (in1),
    .pause_in   (pause_in),
    .read0      (read0),
    .read1      (read1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .arb_error  (arb_error)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: sample pops, take the edge, update the FIFO models, return at negedge.
  task automatic tick();
    #1;
    last_r0 = read0;
    last_r1 = read1;
    tests++;
    if (last_r0 && last_r1) begin
      fails++;
      $display("FAIL read_exclusive: read0=%b read1=%b, required not both 1", last_r0, last_r1);
    end
    @(posedge clk);
    #1;
    if (last_r0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL read0_on_empty: read0=1 while fifo0 empty, required 0");
      end else begin
        in0 = q0.pop_front();
      end
    end
    if (last_r1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL read1_on_empty: read1=1 while fifo1 empty, required 0");
      end else begin
        in1 = q1.pop_front();
      end
    end
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    @(negedge clk);
  endtask

  task automatic load(input int cls, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      if (cls == 0) q0.push_back(base + DW'(k));
      else          q1.push_back(base + DW'(k));
    end
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tests++;
    if (read0 !== 1'b0 || read1 !== 1'b0 || valid_out !== 1'b0 || data_out !== '0 || arb_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: r0=%b r1=%b v=%b d=%h err=%b, required all 0",
               read0, read1, valid_out, data_out, arb_error);
    end
`ifdef ARB_GRANT_CNT_EN
    tests++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_gcnt: cnt0=%0d cnt1=%0d, required 0 0", grant_cnt0, grant_cnt1);
    end
`endif
    reset    = 1'b1;
    exp_data = '0;
  endtask

  // Both-full weighting, FIFO0-only burst, IDLE priority, and pause with credit hold.
  task automatic test_streaming();
    string         sched;
    byte           c;
    byte           prev;
    int            k0;
    int            k1;
    logic          exp_v;
    for (int s = 0; s < 4; s++) begin
      sched = sched_tbl[s];
      k0 = 0;
      k1 = 0;
      load(0, n0_tbl[s], b0_tbl[s]);
      load(1, n1_tbl[s], b1_tbl[s]);
      for (int j = 0; j < sched.len(); j++) begin
        c = sched[j];
        pause_in = (c == "p");
        tick();
        tests++;
        if (last_r0 !== (c == "0") || last_r1 !== (c == "1")) begin
          fails++;
          $display("FAIL sched%0d_read cyc%0d: read0/read1=%b%b, required %b%b",
                   s, j, last_r0, last_r1, (c == "0"), (c == "1"));
        end
        prev  = (j > 0) ? sched[j-1] : "-";
        exp_v = (prev == "0") || (prev == "1");
        if (prev == "1") begin
          exp_data = b1_tbl[s] + DW'(k1);
          k1++;
        end else if (prev == "0") begin
          exp_data = b0_tbl[s] + DW'(k0);
          k0++;
        end
        tests++;
        if (valid_out !== exp_v || data_out !== exp_data) begin
          fails++;
          $display("FAIL sched%0d_data cyc%0d: valid=%b data=%h, required valid=%b data=%h",
                   s, j, valid_out, data_out, exp_v, exp_data);
        end
      end
      pause_in = 1'b0;
`ifdef ARB_GRANT_CNT_EN
      if (s == 0) begin
        tests++;
        if (grant_cnt0 !== 16'd8 || grant_cnt1 !== 16'd8) begin
          fails++;
          $display("FAIL gcnt_after_full: cnt0=%0d cnt1=%0d, required 8 8", grant_cnt0, grant_cnt1);
        end
      end
`endif
    end
  endtask

  task automatic test_error();
    load(1, 8, 10'h240);
    tick();
    tick();
    tests++;
    if (last_r1 !== 1'b1) begin
      fails++;
      $display("FAIL err_pre_read: read1=%b, required 1", last_r1);
    end
    tick();
    tests++;
    if (last_r1 !== 1'b1 || valid_out !== 1'b1 || data_out !== 10'h240) begin
      fails++;
      $display("FAIL err_pre_data: r1=%b v=%b d=%h, required 1 1 240", last_r1, valid_out, data_out);
    end
    fifo1_error = 1'b1;
    tick();
    fifo1_error = 1'b0;
    tests++;
    if (last_r1 !== 1'b1 || valid_out !== 1'b1 || data_out !== 10'h241 || arb_error !== 1'b1) begin
      fails++;
      $display("FAIL err_set: r1=%b v=%b d=%h err=%b, required 1 1 241 1",
               last_r1, valid_out, data_out, arb_error);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (last_r0 !== 1'b0 || last_r1 !== 1'b0 || arb_error !== 1'b1 ||
          valid_out !== (i == 0) || data_out !== 10'h242) begin
        fails++;
        $display("FAIL err_hold cyc%0d: r0=%b r1=%b err=%b v=%b d=%h, required 0 0 1 %b 242",
                 i, last_r0, last_r1, arb_error, valid_out, data_out, (i == 0));
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++;
    if (arb_error !== 1'b0 || valid_out !== 1'b0 || data_out !== '0) begin
      fails++;
      $display("FAIL err_clear: err=%b v=%b d=%h, required 0 0 000", arb_error, valid_out, data_out);
    end
    q1.delete();
    fifo1_empty = 1'b1;
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] w_next;
    load(0, 8, 10'h050);
    load(1, 8, 10'h250);
    tick();
    tick();
    tick();
    tests++;
    if (last_r1 !== 1'b1 || valid_out !== 1'b1 || data_out !== 10'h250) begin
      fails++;
      $display("FAIL mid_pre: r1=%b v=%b d=%h, required 1 1 250", last_r1, valid_out, data_out);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if (read0 !== 1'b0 || read1 !== 1'b0 || valid_out !== 1'b0 || data_out !== '0 || arb_error !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outs: r0=%b r1=%b v=%b d=%h err=%b, required all 0",
               read0, read1, valid_out, data_out, arb_error);
    end
`ifdef ARB_GRANT_CNT_EN
    tests++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      fails++;
      $display("FAIL mid_gcnt_zero: cnt0=%0d cnt1=%0d, required 0 0", grant_cnt0, grant_cnt1);
    end
`endif
    tick();
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL mid_dropped: valid_out=%b, required 0", valid_out);
    end
    w_next = q1[0];
    tick();
    tests++;
    if (last_r1 !== 1'b1 || last_r0 !== 1'b0 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL mid_class1_first: r0=%b r1=%b v=%b, required 0 1 0", last_r0, last_r1, valid_out);
    end
`ifdef ARB_GRANT_CNT_EN
    tests++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd1) begin
      fails++;
      $display("FAIL mid_gcnt_inc: cnt0=%0d cnt1=%0d, required 0 1", grant_cnt0, grant_cnt1);
    end
`endif
    tick();
    tests++;
    if (valid_out !== 1'b1 || data_out !== w_next) begin
      fails++;
      $display("FAIL mid_resume_data: v=%b d=%h, required 1 %h", valid_out, data_out, w_next);
    end
  endtask

  initial begin
    reset       = 1'b0;
    fifo0_empty = 1'b1;
    fifo1_empty = 1'b1;
    fifo0_error = 1'b0;
    fifo1_error = 1'b0;
    in0         = '0;
    in1         = '0;
    pause_in    = 1'b0;
    last_r0     = 1'b0;
    last_r1     = 1'b0;
    exp_data    = '0;
    test_reset();
    test_streaming();
    test_error();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
